dma_pxl_burst_writer: RTL and testbench

DMA_PXL_BURST_WRITER -- requirements
Module: dma_pxl_burst_writer

---
 rtl/dma_pxl_pkg.sv | 27 ++
 rtl/pxl_beat_packer.sv | 82 ++++++++
 rtl/dma_pxl_burst_writer.sv | 164 ++++++++++++++++
 tb/tb_dma_pxl_burst_writer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pxl_pkg.sv
// ---------------------------------------------------------------------------
// dma_pxl_pkg
// Shared definitions for the gray-pixel DMA burst writer:
//   - burst_state_t : encoding of the AW/W/B burst sequencer
//   - ppb_of()      : pixels packed into one DMA beat
//   - PPB           : pixels per beat for the default 256-bit / 8-bit build
//   - DEF_BASE_ADDR : default stream address
//   - DEF_MST_ID    : default AXI write ID
// ---------------------------------------------------------------------------
package dma_pxl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } burst_state_t;

  function automatic int ppb_of(input int data_w, input int pxl_w);
    return data_w / pxl_w;
  endfunction

  localparam int          PPB           = ppb_of(256, 8);
  localparam logic [31:0] DEF_BASE_ADDR = 32'h2000_0000;
  localparam logic [4:0]  DEF_MST_ID    = 5'd0;

endpackage

// File: rtl/pxl_beat_packer.sv
// ---------------------------------------------------------------------------
// pxl_beat_packer
// Packs gray pixels into DMA beats, first pixel in the LSBs. A beat closes
// when it is full or when a frame-last pixel arrives; short beats are zero
// padded. Closed beats sit in a single beat register until the W channel
// takes them.
// Ports:
//   clk, rst         clock / async active-high reset
//   pxl_dat, pxl_vld pixel stream input
//   frm_last         marks the last pixel of a frame
//   beat_take        W handshake of the current beat (from the top)
//   pxl_rdy          pixel ready back to the source
//   beat_vld         beat register holds a beat
//   beat_last        held beat closes a frame
//   beat_dat         held beat data
// ---------------------------------------------------------------------------
module pxl_beat_packer
  import dma_pxl_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int PXL_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PXL_W-1:0]  pxl_dat,
  input  logic              pxl_vld,
  input  logic              frm_last,
  input  logic              beat_take,
  output logic              pxl_rdy,
  output logic              beat_vld,
  output logic              beat_last,
  output logic [DATA_W-1:0] beat_dat
);

  localparam int PPB_L = ppb_of(DATA_W, PXL_W);
  localparam int CW    = (PPB_L > 1) ? $clog2(PPB_L) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(PPB_L - 1);

  logic [CW-1:0]     pack_cnt;
  logic [DATA_W-1:0] pack_reg;
  logic [DATA_W-1:0] pack_nxt;
  logic              accept;
  logic              beat_end;

  // A beat leaving on W this cycle frees the register for a new one.
  assign pxl_rdy  = !beat_vld | beat_take;
  assign accept   = pxl_vld & pxl_rdy;
  assign beat_end = frm_last | (pack_cnt == LAST_SLOT);

  always_comb begin
    pack_nxt = pack_reg;
    pack_nxt[int'(pack_cnt) * PXL_W +: PXL_W] = pxl_dat;
  end

  // Closing a beat clears the pack register, which zero-pads short beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_cnt  <= '0;
      pack_reg  <= '0;
      beat_vld  <= 1'b0;
      beat_last <= 1'b0;
      beat_dat  <= '0;
    end else begin
      if (beat_take) begin
        beat_vld <= 1'b0;
      end
      if (accept) begin
        if (beat_end) begin
          beat_dat  <= pack_nxt;
          beat_vld  <= 1'b1;
          beat_last <= frm_last;
          pack_reg  <= '0;
          pack_cnt  <= '0;
        end else begin
          pack_reg <= pack_nxt;
          pack_cnt <= pack_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dma_pxl_burst_writer.sv
// ---------------------------------------------------------------------------
// dma_pxl_burst_writer
// Streams gray pixels to memory as AXI4 write bursts at a fixed address with
// one outstanding burst. Bursts end after BURST_LEN beats or on a frame-last
// beat. A bad B response or ID sets a sticky error flag.
// Ports:
//   clk, rst                       clock / async active-high reset
//   pxl_dat_i/pxl_vld_i/frm_last_i pixel stream in, pxl_rdy_o ready out
//   m_aw*                          AXI write address channel
//   m_w*                           AXI write data channel
//   m_b*                           AXI write response channel
//   frm_done_o                     one-cycle pulse when a frame is acknowledged
//   err_o                          sticky error, cleared only by reset
// Build option: define DMA_PXL_B_TIMEOUT_EN to abandon the B wait after
// B_TIMEOUT_CYC cycles (sets err_o); otherwise B waits indefinitely.
// ---------------------------------------------------------------------------
module dma_pxl_burst_writer
  import dma_pxl_pkg::*;
#(
  parameter int                  DATA_W    = 256,
  parameter int                  ADDR_W    = 32,
  parameter int                  MST_ID_W  = 5,
  parameter int                  PXL_W     = 8,
  parameter int                  BURST_LEN = 16,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [MST_ID_W-1:0] MST_ID    = DEF_MST_ID
`ifdef DMA_PXL_B_TIMEOUT_EN
  ,
  parameter int                  B_TIMEOUT_CYC = 1024
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PXL_W-1:0]    pxl_dat_i,
  input  logic                pxl_vld_i,
  input  logic                frm_last_i,
  output logic                pxl_rdy_o,
  output logic [MST_ID_W-1:0] m_awid_o,
  output logic [ADDR_W-1:0]   m_awaddr_o,
  output logic                m_awvalid_o,
  input  logic                m_awready_i,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic                m_wlast_o,
  output logic                m_wvalid_o,
  input  logic                m_wready_i,
  input  logic [MST_ID_W-1:0] m_bid_i,
  input  logic [1:0]          m_bresp_i,
  input  logic                m_bvalid_i,
  output logic                m_bready_o,
  output logic                frm_done_o,
  output logic                err_o
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  burst_state_t      state;
  burst_state_t      state_nxt;
  logic [CNT_W-1:0]  beat_cnt;
  logic              frm_flag;
  logic              beat_vld;
  logic              beat_last;
  logic              beat_take;
  logic              b_hs;
  logic              b_bad;
  logic              to_expire;

  assign beat_take  = m_wvalid_o & m_wready_i;
  assign b_hs       = (state == S_B) & m_bvalid_i;
  assign b_bad      = (m_bresp_i != 2'b00) | (m_bid_i != MST_ID);
  assign m_awid_o   = MST_ID;
  assign m_awaddr_o = BASE_ADDR;

  pxl_beat_packer #(
    .DATA_W (DATA_W),
    .PXL_W  (PXL_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .pxl_dat   (pxl_dat_i),
    .pxl_vld   (pxl_vld_i),
    .frm_last  (frm_last_i),
    .beat_take (beat_take),
    .pxl_rdy   (pxl_rdy_o),
    .beat_vld  (beat_vld),
    .beat_last (beat_last),
    .beat_dat  (m_wdata_o)
  );

`ifdef DMA_PXL_B_TIMEOUT_EN
  localparam int TO_W = (B_TIMEOUT_CYC > 1) ? $clog2(B_TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt;

  // Counts B cycles without a response; held at zero outside B so every
  // entry into B starts a fresh window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != S_B) begin
      to_cnt <= '0;
    end else if (!m_bvalid_i) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_expire = (state == S_B) & !m_bvalid_i & (to_cnt == TO_W'(B_TIMEOUT_CYC - 1));
`else
  assign to_expire = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_wlast_o   = 1'b0;
    m_bready_o  = 1'b0;
    case (state)
      S_IDLE: begin
        if (beat_vld) state_nxt = S_AW;
      end
      S_AW: begin
        m_awvalid_o = 1'b1;
        if (m_awready_i) state_nxt = S_W;
      end
      S_W: begin
        m_wvalid_o = beat_vld;
        m_wlast_o  = beat_vld & (beat_last | (beat_cnt == LAST_IDX));
        if (beat_take & m_wlast_o) state_nxt = S_B;
      end
      S_B: begin
        m_bready_o = 1'b1;
        if (m_bvalid_i | to_expire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // frm_flag remembers whether the burst in flight closes a frame, so the
  // done pulse can follow its B handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      frm_flag   <= 1'b0;
      frm_done_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state      <= state_nxt;
      frm_done_o <= b_hs & frm_flag;
      if (state == S_AW) begin
        beat_cnt <= '0;
      end else if (beat_take) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (beat_take & m_wlast_o) begin
        frm_flag <= beat_last;
      end
      if ((b_hs & b_bad) | to_expire) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_pxl_burst_writer.sv
// ---------------------------------------------------------------------------
// tb_dma_pxl_burst_writer
// Directed bench for dma_pxl_burst_writer with a scoreboard of expected
// beats built from the pixels the DUT accepts, and a configurable AXI slave.
// ---------------------------------------------------------------------------
module tb_dma_pxl_burst_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   pxl_dat;
  logic         pxl_vld;
  logic         frm_last;
  logic         pxl_rdy_o;
  logic [4:0]   m_awid_o;
  logic [31:0]  m_awaddr_o;
  logic         m_awvalid_o;
  logic         m_awready_i;
  logic [255:0] m_wdata_o;
  logic         m_wlast_o;
  logic         m_wvalid_o;
  logic         m_wready_i;
  logic [4:0]   m_bid_i;
  logic [1:0]   m_bresp_i;
  logic         m_bvalid_i;
  logic         m_bready_o;
  logic         frm_done_o;
  logic         err_o;

  always #5 clk = ~clk;

  dma_pxl_burst_writer dut (
    .clk         (clk),
    .rst         (rst),
    .pxl_dat_i   (pxl_dat),
    .pxl_vld_i   (pxl_vld),
    .frm_last_i  (frm_last),
    .pxl_rdy_o   (pxl_rdy_o),
    .m_awid_o    (m_awid_o),
    .m_awaddr_o  (m_awaddr_o),
    .m_awvalid_o (m_awvalid_o),
    .m_awready_i (m_awready_i),
    .m_wdata_o   (m_wdata_o),
    .m_wlast_o   (m_wlast_o),
    .m_wvalid_o  (m_wvalid_o),
    .m_wready_i  (m_wready_i),
    .m_bid_i     (m_bid_i),
    .m_bresp_i   (m_bresp_i),
    .m_bvalid_i  (m_bvalid_i),
    .m_bready_o  (m_bready_o),
    .frm_done_o  (frm_done_o),
    .err_o       (err_o)
  );

  typedef struct {
    logic [255:0] data;
    logic         last;
  } beat_t;

  beat_t        sb[$];
  beat_t        exp_beat;
  int           tests_run    = 0;
  int           tests_failed = 0;
  logic [255:0] mdl_beat;
  int           mdl_cnt;
  int           mdl_pos;
  int           exp_bursts;
  int           exp_frames;
  int           b_hs_cnt;
  int           frm_done_cnt;

  int           aw_stall;
  int           aw_wait;
  bit           w_toggle;
  bit           w_hold;
  bit           b_withhold;
  logic [1:0]   bresp_val;

  bit           aw_done;
  bit           aw_stall_prev;
  logic [31:0]  aw_addr_prev;
  bit           w_stall_prev;
  logic [255:0] w_data_prev;
  logic         w_last_prev;
  logic         fd_prev;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference packing model: 32 pixels per beat, LSB first; bursts end on
  // the 16th beat or a frame-last beat.
  task automatic modelPixel(input logic [7:0] p, input logic last);
    beat_t b;
    mdl_beat[mdl_cnt*8 +: 8] = p;
    mdl_cnt++;
    if (mdl_cnt == 32 || last) begin
      b.data = mdl_beat;
      b.last = last || (mdl_pos == 15);
      sb.push_back(b);
      if (b.last) begin
        exp_bursts++;
        mdl_pos = 0;
      end else begin
        mdl_pos++;
      end
      if (last) exp_frames++;
      mdl_beat = '0;
      mdl_cnt  = 0;
    end
  endtask

  task automatic clearModel();
    sb.delete();
    mdl_beat     = '0;
    mdl_cnt      = 0;
    mdl_pos      = 0;
    exp_bursts   = 0;
    exp_frames   = 0;
    b_hs_cnt     = 0;
    frm_done_cnt = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_awvalid"}, m_awvalid_o, 0);
    checkOutput({tag, "_wvalid"}, m_wvalid_o, 0);
    checkOutput({tag, "_wlast"}, m_wlast_o, 0);
    checkOutput({tag, "_bready"}, m_bready_o, 0);
    checkOutput({tag, "_frm_done"}, frm_done_o, 0);
    checkOutput({tag, "_err"}, err_o, 0);
    checkOutput({tag, "_wdata"}, m_wdata_o, 0);
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    clearModel();
    repeat (2) @(negedge clk);
    checkResetOutputs(tag);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_pxl_rdy"}, pxl_rdy_o, 1);
  endtask

  // Drives n pixels (values start, start+1, ... mod 256) one per accept,
  // optionally marking the final one frame-last.
  task automatic applyStimulus(input int n, input int start, input bit last_end);
    int waited;
    logic [7:0] p;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      p        = 8'((start + i) % 256);
      pxl_vld  = 1'b1;
      pxl_dat  = p;
      frm_last = last_end && (i == n - 1);
      waited   = 0;
      @(negedge clk);
      while (!pxl_rdy_o && waited < 500) begin
        @(negedge clk);
        waited++;
      end
      if (!pxl_rdy_o) begin
        checkOutput("pxl_accept_timeout", 0, 1);
        break;
      end
      modelPixel(p, frm_last);
      @(posedge clk);
      #1;
    end
    pxl_vld  = 1'b0;
    frm_last = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || b_hs_cnt != exp_bursts) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_drained"}, (sb.size() == 0 && b_hs_cnt == exp_bursts), 1);
    repeat (2) @(negedge clk);
  endtask

  // AXI slave model driven just after each rising edge.
  initial begin
    m_awready_i = 1'b0;
    m_wready_i  = 1'b0;
    m_bvalid_i  = 1'b0;
    m_bresp_i   = 2'b00;
    m_bid_i     = 5'd0;
    aw_wait     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (m_awvalid_o) begin
        if (aw_wait < aw_stall) begin
          m_awready_i = 1'b0;
          aw_wait++;
        end else begin
          m_awready_i = 1'b1;
        end
      end else begin
        m_awready_i = 1'b0;
        aw_wait     = 0;
      end
      if (w_hold)        m_wready_i = 1'b0;
      else if (w_toggle) m_wready_i = ~m_wready_i;
      else               m_wready_i = 1'b1;
      m_bvalid_i = m_bready_o && !b_withhold;
      m_bresp_i  = bresp_val;
      m_bid_i    = 5'd0;
    end
  end

  // Protocol monitor and scoreboard checker, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      aw_done       = 1'b0;
      aw_stall_prev = 1'b0;
      w_stall_prev  = 1'b0;
      fd_prev       = 1'b0;
    end else begin
      if (aw_stall_prev) begin
        checkOutput("aw_valid_held", m_awvalid_o, 1);
        checkOutput("aw_addr_held", m_awaddr_o, aw_addr_prev);
      end
      if (w_stall_prev) begin
        checkOutput("w_valid_held", m_wvalid_o, 1);
        checkOutput("w_data_held", m_wdata_o, w_data_prev);
        checkOutput("w_last_held", m_wlast_o, w_last_prev);
      end
      if (m_awvalid_o && m_awready_i) begin
        checkOutput("aw_addr", m_awaddr_o, 32'h2000_0000);
        checkOutput("aw_id", m_awid_o, 0);
        checkOutput("aw_one_outstanding", aw_done, 0);
        aw_done = 1'b1;
      end
      if (m_wvalid_o) checkOutput("w_after_aw", aw_done, 1);
      if (m_wvalid_o && m_wready_i) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 1, 0);
        end else begin
          exp_beat = sb.pop_front();
          checkOutput("w_data", m_wdata_o, exp_beat.data);
          checkOutput("w_last", m_wlast_o, exp_beat.last);
        end
      end
      if (m_wvalid_o && !m_wready_i) checkOutput("pxl_rdy_when_full", pxl_rdy_o, 0);
      if (m_bvalid_i && m_bready_o) begin
        b_hs_cnt++;
        aw_done = 1'b0;
      end
      if (frm_done_o) begin
        frm_done_cnt++;
        checkOutput("frm_done_width", fd_prev, 0);
      end
      fd_prev       = frm_done_o;
      aw_stall_prev = m_awvalid_o && !m_awready_i;
      aw_addr_prev  = m_awaddr_o;
      w_stall_prev  = m_wvalid_o && !m_wready_i;
      w_data_prev   = m_wdata_o;
      w_last_prev   = m_wlast_o;
    end
  end

  initial begin
    rst        = 1'b1;
    pxl_dat    = 8'd0;
    pxl_vld    = 1'b0;
    frm_last   = 1'b0;
    aw_stall   = 0;
    w_toggle   = 1'b0;
    w_hold     = 1'b0;
    b_withhold = 1'b0;
    bresp_val  = 2'b00;

    doReset("reset");

    // Full 16-beat burst from 512 pixels, no frame end.
    applyStimulus(512, 0, 1'b0);
    waitDrain("burst16");
    checkOutput("burst16_bursts", b_hs_cnt, 1);
    checkOutput("burst16_no_frm_done", frm_done_cnt, 0);

    // 40-pixel frame: one full beat, one padded frame-last beat.
    applyStimulus(40, 0, 1'b1);
    waitDrain("frame40");
    checkOutput("frame40_frm_done", frm_done_cnt, exp_frames);
    checkOutput("frame40_err", err_o, 0);

    // AW ready held off for 10 cycles.
    aw_stall = 10;
    applyStimulus(32, 64, 1'b1);
    waitDrain("aw_stall");
    aw_stall = 0;

    // W ready toggling.
    w_toggle = 1'b1;
    applyStimulus(64, 5, 1'b1);
    waitDrain("w_toggle");
    w_toggle = 1'b0;
    checkOutput("w_toggle_err", err_o, 0);

    // SLVERR response sets sticky error that survives a clean burst.
    bresp_val = 2'b10;
    applyStimulus(32, 9, 1'b1);
    waitDrain("slverr");
    checkOutput("slverr_err", err_o, 1);
    bresp_val = 2'b00;
    applyStimulus(32, 11, 1'b1);
    waitDrain("after_err");
    checkOutput("after_err_sticky", err_o, 1);

`ifdef DMA_PXL_B_TIMEOUT_EN
    begin
      int n;
      doReset("pre_timeout");
      b_withhold = 1'b1;
      applyStimulus(32, 3, 1'b1);
      n = 0;
      while (!m_bready_o && n < 500) begin
        @(negedge clk);
        n++;
      end
      checkOutput("timeout_enter_b", m_bready_o, 1);
      n = 0;
      while (m_bready_o && n < 1100) begin
        n++;
        @(negedge clk);
      end
      checkOutput("timeout_window", (n >= 1024 && n <= 1025), 1);
      checkOutput("timeout_err", err_o, 1);
      checkOutput("timeout_idle_bready", m_bready_o, 0);
      checkOutput("timeout_idle_awvalid", m_awvalid_o, 0);
      b_withhold = 1'b0;
    end
`endif

    // Mid-burst reset with a beat stalled on W.
    doReset("pre_midrst");
    w_hold = 1'b1;
    applyStimulus(32, 7, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("midrst_w_stalled", m_wvalid_o, 1);
    @(posedge clk);
    #1;
    doReset("midrst");
    w_hold = 1'b0;
    applyStimulus(32, 100, 1'b1);
    waitDrain("post_midrst");
    checkOutput("post_midrst_frm_done", frm_done_cnt, 1);
    checkOutput("post_midrst_err", err_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
